bit_serial_addsub: RTL
======================

# bit_serial_addsub

Parametrised bit-serial adder/subtractor: loads two WIDTH-bit operands on a start handshake and processes one bit per clock, LSB first, through a single full-adder slice with a registered carry. It returns sum, carry-out and signed overflow with a one-cycle done pulse. It is the general-width, add/subtract, handshaked successor to the fixed 8-bit serial adder in the arithmetic datapath.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (low = reset).
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = A+B, 1 = A-B; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; results valid from this cycle.
- sum  output  WIDTH  result, LSB-first shift register.
- c_out  output  1  final carry; in subtract mode 1 = no borrow.
- overflow  output  1  two's-complement overflow of the operation.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE → SHIFT on start=1:
  - Load A shift register with a. Load B shift register with b, or with ~b when mode=1.
  - Set carry register to mode, so subtraction is A + ~B + 1.
  - Set bit counter to 0.
- SHIFT, each edge:
  - s = A[0]^B'[0]^carry; carry ← majority(A[0], B'[0], carry).
  - A and B' shift right by 1.
  - sum shifts right with s entering at bit WIDTH-1.
  - Counter increments.
- On the edge with counter = WIDTH-1:
  - overflow ← (carry into MSB) ^ (carry out of MSB).
  - c_out ← carry out of MSB.
  - Next state is DONE.
- DONE → IDLE unconditionally after one cycle.
- sum, c_out and overflow hold their values until the next accepted start. On that accept, sum, c_out and overflow clear to 0.
- start is ignored in SHIFT and DONE. There is no queueing. a, b and mode may change freely after they are accepted.
- Arithmetic is modulo 2^WIDTH. The counter width is $clog2(WIDTH).

## Timing
- Reset (rst low, asynchronous): state = IDLE; busy, done, sum, c_out, overflow, carry, counter and shift registers = 0. Reset takes effect immediately, including mid-operation. The operation in progress is lost.
- Release: the first start can be accepted on the first rising edge with rst high.
- Let edge E0 be the edge that samples start in IDLE.
  - busy goes high after E0.
  - Bits 0..WIDTH-1 are processed on edges E1..E_WIDTH.
  - done = 1 for exactly the cycle between E_WIDTH and E_WIDTH+1.
  - busy falls after E_WIDTH+1.
- Latency from start to done is WIDTH cycles. Throughput is one operation per WIDTH+2 cycles.
- start held high continuously: a new operation is accepted on the first edge back in IDLE.

## Test plan
- WIDTH=8, add 0xCD + 0xC4 → sum 0x91, c_out 1, overflow 0; done exactly 8 cycles after the start edge, high for 1 cycle.
- WIDTH=8, subtract 0x05 − 0x07 → sum 0xFE, c_out 0, overflow 0. Subtract 0x80 − 0x01 → sum 0x7F, c_out 1, overflow 1.
- WIDTH=8, add 0x7F + 0x01 → sum 0x80, c_out 0, overflow 1. Add 0x00 + 0x00 → sum 0x00, all flags 0.
- Pulse start again with different operands 3 cycles into an operation → ignored; the original result completes unchanged and no second done occurs.
- Drive rst low at bit 4 of an operation → all outputs 0 immediately, without waiting for a clock edge. After release, a new 0x01 + 0x01 returns 0x02.
- WIDTH=16, add 0xFFFF + 0x0001 → sum 0x0000, c_out 1, overflow 0; done 16 cycles after start. Back-to-back starts are accepted every 18 cycles.

Source files
------------

// File: rtl/bit_serial_addsub.sv
// Bit-serial add/subtract: one full-adder slice, registered carry, LSB first.
// Latency: done pulses WIDTH cycles after the start edge; one op per WIDTH+2 cycles.
// Backpressure: start is taken only in IDLE; requests while busy are dropped, not queued.
module bit_serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_bit;
    logic             accept;
    logic             last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_bit     = a_sr[0] ^ b_sr[0] ^ carry;
        c_bit     = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        accept    = (state == IDLE) && start;
        last      = (state == SHIFT) && (cnt == LAST);
        unique case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Subtraction is A + ~B + 1: B is inverted at load and the carry seeded with mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sr     <= a;
            b_sr     <= mode ? ~b : b;
            carry    <= mode;
            cnt      <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (state == SHIFT) begin
            a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
            carry <= c_bit;
            sum   <= {s_bit, sum[WIDTH-1:1]};
            cnt   <= cnt + CW'(1);
            if (last) begin
                // carry still holds the carry into the MSB on this edge
                overflow <= carry ^ c_bit;
                c_out    <= c_bit;
            end
        end
    end

endmodule
